// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: pipeline WB writes win, MDU results queue in a
// small FIFO and drain on idle WB cycles or on a forced one-cycle stall.
module wb_port_arbiter #(
  parameter int DEPTH      = 4,
  parameter int STARVE_MAX = 4
) (
  input  logic                       clk,
  input  logic                       clrn,
  input  logic                       wb_wreg,
  input  logic [4:0]                 wb_wn,
  input  logic [31:0]                wb_d,
  input  logic                       mdu_valid,
  input  logic [4:0]                 mdu_wn,
  input  logic [31:0]                mdu_d,
  output logic                       mdu_ready,
  output logic                       rf_we,
  output logic [4:0]                 rf_wn,
  output logic [31:0]                rf_d,
  output logic                       stall_req,
  input  logic [4:0]                 qa_n,
  input  logic [4:0]                 qb_n,
  output logic                       pend_a,
  output logic                       pend_b,
  output logic [$clog2(DEPTH+1)-1:0] fifo_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam int SW = $clog2(STARVE_MAX+1);
  localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX-1);

  logic [4:0]       r_wn [DEPTH];
  logic [31:0]      r_d  [DEPTH];
  logic [DEPTH-1:0] r_vld;
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_cnt;
  logic [SW-1:0]    r_starve;
  logic             r_stall;

  logic             w_empty;
  logic             w_wb_req;
  logic             w_ready;
  logic             w_pop;
  logic             w_grant_wb;
  logic             w_push;
  logic [DEPTH-1:0] w_hit_a;
  logic [DEPTH-1:0] w_hit_b;

  assign w_empty    = (r_cnt == '0);
  assign w_wb_req   = wb_wreg && (wb_wn != 5'd0);
  assign w_ready    = clrn && (r_cnt < CW'(DEPTH));
  // A pending forced stall overrides the pipeline; otherwise the FIFO only fills idle slots.
  assign w_pop      = clrn && !w_empty && (r_stall || !w_wb_req);
  assign w_grant_wb = clrn && w_wb_req && !(r_stall && !w_empty);
  // Results aimed at r0 complete the handshake but are never stored.
  assign w_push     = mdu_valid && w_ready && (mdu_wn != 5'd0);

  assign mdu_ready = w_ready;
  assign rf_we     = w_pop || w_grant_wb;
  assign rf_wn     = w_pop ? r_wn[r_rd_ptr] : (w_grant_wb ? wb_wn : 5'd0);
  assign rf_d      = w_pop ? r_d[r_rd_ptr]  : (w_grant_wb ? wb_d  : 32'd0);
  assign stall_req = r_stall;
  assign fifo_cnt  = r_cnt;

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_pend
    assign w_hit_a[gi] = r_vld[gi] && (r_wn[gi] == qa_n);
    assign w_hit_b[gi] = r_vld[gi] && (r_wn[gi] == qb_n);
  end

  assign pend_a = clrn && (qa_n != 5'd0) && (|w_hit_a);
  assign pend_b = clrn && (qb_n != 5'd0) && (|w_hit_b);

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_wn[r_wr_ptr] <= mdu_wn;
      r_d[r_wr_ptr]  <= mdu_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!clrn) begin
      r_vld    <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_cnt    <= '0;
      r_starve <= '0;
      r_stall  <= 1'b0;
    end else begin
      // Push and pop never hit the same slot: that needs an empty or full FIFO.
      if (w_pop) begin
        r_vld[r_rd_ptr] <= 1'b0;
        r_rd_ptr        <= r_rd_ptr + AW'(1);
      end
      if (w_push) begin
        r_vld[r_wr_ptr] <= 1'b1;
        r_wr_ptr        <= r_wr_ptr + AW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + CW'(1);
        2'b01:   r_cnt <= r_cnt - CW'(1);
        default: r_cnt <= r_cnt;
      endcase
      r_starve <= (w_pop || w_empty) ? '0 : r_starve + SW'(1);
      r_stall  <= !w_empty && !w_pop && !r_stall && (r_starve == STARVE_LIM);
    end
  end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Randomized and directed bench for wb_port_arbiter against a queue-based reference model.
module tb_wb_port_arbiter;
  localparam int DEPTH      = 4;
  localparam int STARVE_MAX = 4;
  localparam int CW         = $clog2(DEPTH+1);

  logic          clk = 1'b0;
  logic          clrn;
  logic          wb_wreg;
  logic [4:0]    wb_wn;
  logic [31:0]   wb_d;
  logic          mdu_valid;
  logic [4:0]    mdu_wn;
  logic [31:0]   mdu_d;
  logic          mdu_ready;
  logic          rf_we;
  logic [4:0]    rf_wn;
  logic [31:0]   rf_d;
  logic          stall_req;
  logic [4:0]    qa_n;
  logic [4:0]    qb_n;
  logic          pend_a;
  logic          pend_b;
  logic [CW-1:0] fifo_cnt;

  always #5 clk = ~clk;

  wb_port_arbiter #(.DEPTH(DEPTH), .STARVE_MAX(STARVE_MAX)) dut (
    .clk(clk), .clrn(clrn), .wb_wreg(wb_wreg), .wb_wn(wb_wn), .wb_d(wb_d),
    .mdu_valid(mdu_valid), .mdu_wn(mdu_wn), .mdu_d(mdu_d), .mdu_ready(mdu_ready),
    .rf_we(rf_we), .rf_wn(rf_wn), .rf_d(rf_d), .stall_req(stall_req),
    .qa_n(qa_n), .qb_n(qb_n), .pend_a(pend_a), .pend_b(pend_b), .fifo_cnt(fifo_cnt)
  );

  typedef struct packed {
    logic [4:0]  wn;
    logic [31:0] d;
  } ent_t;

  ent_t m_q[$];
  int   m_starve = 0;
  bit   m_stall  = 1'b0;
  bit   m_known  = 1'b0;

  int n_vec      = 0;
  int n_miscmp   = 0;

  logic        obs_we, obs_ready, obs_stall, obs_pa;
  logic [4:0]  obs_wn;
  logic [31:0] obs_d;
  logic [CW-1:0] obs_cnt;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miscmp++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // One clock: drive inputs, compare every output with the model, then advance both.
  task automatic step(input logic wreg, input logic [4:0] wn, input logic [31:0] d,
                      input logic mv, input logic [4:0] mwn, input logic [31:0] md,
                      input logic [4:0] qa, input logic [4:0] qb);
    bit          e_empty, e_pop, e_wb, e_we, e_ready, e_pa, e_pb, e_push, nxt_stall;
    logic [4:0]  e_wn;
    logic [31:0] e_d;
    wb_wreg = wreg; wb_wn = wn; wb_d = d;
    mdu_valid = mv; mdu_wn = mwn; mdu_d = md;
    qa_n = qa; qb_n = qb;
    #1;
    e_empty = (m_q.size() == 0);
    e_pop = 1'b0;
    e_wb  = 1'b0;
    if (clrn) begin
      if (m_stall && !e_empty)  e_pop = 1'b1;
      else if (wreg && wn != 0) e_wb  = 1'b1;
      else if (!e_empty)        e_pop = 1'b1;
    end
    e_we    = e_pop || e_wb;
    e_wn    = e_pop ? m_q[0].wn : (e_wb ? wn : 5'd0);
    e_d     = e_pop ? m_q[0].d  : (e_wb ? d  : 32'd0);
    e_ready = clrn && (m_q.size() < DEPTH);
    e_pa = 1'b0;
    e_pb = 1'b0;
    foreach (m_q[i]) begin
      if (m_q[i].wn == qa) e_pa = 1'b1;
      if (m_q[i].wn == qb) e_pb = 1'b1;
    end
    e_pa = e_pa && clrn && (qa != 0);
    e_pb = e_pb && clrn && (qb != 0);

    check_val("rf_we", 32'(rf_we), 32'(e_we));
    check_val("rf_wn", 32'(rf_wn), 32'(e_wn));
    check_val("rf_d", rf_d, e_d);
    check_val("mdu_ready", 32'(mdu_ready), 32'(e_ready));
    check_val("pend_a", 32'(pend_a), 32'(e_pa));
    check_val("pend_b", 32'(pend_b), 32'(e_pb));
    if (m_known) begin
      check_val("stall_req", 32'(stall_req), 32'(m_stall));
      check_val("fifo_cnt", 32'(fifo_cnt), 32'(m_q.size()));
    end
    obs_we = rf_we; obs_wn = rf_wn; obs_d = rf_d; obs_ready = mdu_ready;
    obs_stall = stall_req; obs_pa = pend_a; obs_cnt = fifo_cnt;
    if (e_pop)
      $display("retire mdu wn=%0d d=0x%0h stall=%0b t=%0t", e_wn, e_d, m_stall, $time);

    @(posedge clk);
    if (!clrn) begin
      m_q.delete();
      m_starve = 0;
      m_stall  = 1'b0;
      m_known  = 1'b1;
    end else begin
      e_push    = mv && e_ready && (mwn != 0);
      nxt_stall = !e_empty && !e_pop && !m_stall && (m_starve == STARVE_MAX-1);
      if (e_pop)  void'(m_q.pop_front());
      if (e_push) m_q.push_back(ent_t'{wn: mwn, d: md});
      m_starve = (e_pop || e_empty) ? 0 : m_starve + 1;
      m_stall  = nxt_stall;
    end
    #1;
  endtask

  task automatic idle();
    step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
  endtask

  initial begin
    int pct;
    clrn = 1'b0;
    // Reset with active requests on both sides.
    step(1'b1, 5'd3, 32'h11, 1'b1, 5'd4, 32'h22, 5'd4, 5'd3);
    step(1'b1, 5'd3, 32'h11, 1'b1, 5'd4, 32'h22, 5'd4, 5'd3);
    check_val("rst_we", 32'(obs_we), 32'd0);
    check_val("rst_ready", 32'(obs_ready), 32'd0);
    check_val("rst_cnt", 32'(obs_cnt), 32'd0);
    clrn = 1'b1;
    idle();
    check_val("post_rst_ready", 32'(obs_ready), 32'd1);

    // Idle drain.
    step(1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 32'h1234, 5'd0, 5'd0);
    idle();
    check_val("drain_we", 32'(obs_we), 32'd1);
    check_val("drain_wn", 32'(obs_wn), 32'd5);
    check_val("drain_d", obs_d, 32'h1234);
    idle();
    check_val("drain_cnt", 32'(obs_cnt), 32'd0);

    // Priority and starvation.
    step(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'hA, 5'd0, 5'd0);
    for (int i = 0; i < STARVE_MAX; i++) begin
      step(1'b1, 5'd3, 32'h300 + i, 1'b0, 5'd0, 32'd0, 5'd7, 5'd0);
      check_val("prio_wn", 32'(obs_wn), 32'd3);
      check_val("prio_nostall", 32'(obs_stall), 32'd0);
    end
    step(1'b1, 5'd3, 32'h399, 1'b0, 5'd0, 32'd0, 5'd7, 5'd0);
    check_val("starve_stall", 32'(obs_stall), 32'd1);
    check_val("starve_wn", 32'(obs_wn), 32'd7);
    check_val("starve_d", obs_d, 32'hA);
    step(1'b1, 5'd3, 32'h3AA, 1'b0, 5'd0, 32'd0, 5'd7, 5'd0);
    check_val("resume_stall", 32'(obs_stall), 32'd0);
    check_val("resume_wn", 32'(obs_wn), 32'd3);

    // Full FIFO under a saturated pipeline.
    for (int i = 0; i < DEPTH; i++)
      step(1'b1, 5'd3, 32'h40, 1'b1, 5'(8 + i), 32'h800 + i, 5'd0, 5'd0);
    step(1'b1, 5'd3, 32'h41, 1'b1, 5'd13, 32'hDEAD, 5'd13, 5'd8);
    check_val("full_ready", 32'(obs_ready), 32'd0);
    check_val("full_cnt", 32'(obs_cnt), 32'(DEPTH));
    step(1'b1, 5'd3, 32'h42, 1'b0, 5'd0, 32'd0, 5'd13, 5'd0);
    step(1'b1, 5'd3, 32'h43, 1'b0, 5'd0, 32'd0, 5'd13, 5'd0);
    check_val("after_pop_ready", 32'(obs_ready), 32'd1);
    for (int i = 0; i < DEPTH; i++) idle();

    // r0 handling.
    step(1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 32'h99, 5'd0, 5'd0);
    step(1'b1, 5'd0, 32'h55, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
    check_val("r0_we", 32'(obs_we), 32'd1);
    check_val("r0_wn", 32'(obs_wn), 32'd9);
    step(1'b1, 5'd3, 32'h66, 1'b1, 5'd0, 32'h77, 5'd0, 5'd0);
    step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
    check_val("r0_push_cnt", 32'(obs_cnt), 32'd0);
    check_val("r0_push_we", 32'(obs_we), 32'd0);

    // Pending tracking.
    step(1'b1, 5'd3, 32'h1, 1'b1, 5'd12, 32'hC, 5'd12, 5'd0);
    check_val("pend_before", 32'(obs_pa), 32'd0);
    step(1'b1, 5'd3, 32'h2, 1'b0, 5'd0, 32'd0, 5'd12, 5'd0);
    check_val("pend_queued", 32'(obs_pa), 32'd1);
    step(1'b1, 5'd3, 32'h3, 1'b0, 5'd0, 32'd0, 5'd0, 5'd12);
    check_val("pend_r0", 32'(obs_pa), 32'd0);
    step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd12, 5'd0);
    check_val("pend_popcycle", 32'(obs_pa), 32'd1);
    step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd12, 5'd0);
    check_val("pend_after", 32'(obs_pa), 32'd0);

    // Push/pop pairs across pointer wrap.
    for (int i = 0; i < 10; i++)
      step(1'b0, 5'd0, 32'd0, 1'b1, 5'(16 + i), 32'hF000 + i, 5'(16 + i), 5'(15 + i));
    idle();

    // Randomized phases with varying pipeline load and occasional resets.
    for (int c = 0; c < 2400; c++) begin
      if (c % 200 == 0) pct = (c / 200) % 3 == 0 ? 20 : ((c / 200) % 3 == 1 ? 60 : 95);
      clrn = ($urandom_range(0, 199) != 0);
      step(($urandom_range(0, 99) < pct), 5'($urandom_range(0, 31)), $urandom,
           ($urandom_range(0, 99) < 55), 5'($urandom_range(0, 15)), $urandom,
           5'($urandom_range(0, 15)), 5'($urandom_range(0, 15)));
    end
    clrn = 1'b1;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
    $finish;
  end

endmodule

// File: doc/wb_port_arbiter.md
# wb_port_arbiter

Shares the single register-file write port between the in-order pipeline's WB stage and a long-latency multiply/divide unit (MDU). Pipeline writes win by default. MDU results wait in a small FIFO and drain on idle WB cycles. A starvation counter forces a one-cycle pipeline stall so queued results always retire. The block also reports pending queued destinations to the hazard logic, so dependent instructions stall until their operand is written.

## Interface
- DEPTH, 4, MDU result FIFO entries (power of two, ≥2)
- STARVE_MAX, 4, cycles a non-empty FIFO may go unserved before stall_req fires (≥1)
- clk  in  1  clock; all state updates on rising edge
- clrn  in  1  reset, synchronous, active-low
- wb_wreg  in  1  pipeline WB write enable
- wb_wn  in  5  pipeline WB destination register
- wb_d  in  32  pipeline WB data (already muxed ALU/memory result)
- mdu_valid  in  1  MDU result offered
- mdu_wn  in  5  MDU destination register
- mdu_d  in  32  MDU result data
- mdu_ready  out  1  FIFO can accept this cycle
- rf_we  out  1  register-file write enable
- rf_wn  out  5  register-file write address
- rf_d  out  32  register-file write data
- stall_req  out  1  pipeline must present a WB bubble this cycle
- qa_n, qb_n  in  5  source registers being decoded
- pend_a, pend_b  out  1  matching destination is queued in the FIFO
- fifo_cnt  out  $clog2(DEPTH+1)  occupied entries

## Operation
- Pipeline request: wb_req = wb_wreg && wb_wn != 0. Writes to r0 are never issued.
- Grant, evaluated combinationally each cycle:
  - stall_req=1 and FIFO non-empty: grant FIFO head. wb_* is ignored; the pipeline contract is a bubble.
  - else wb_req=1: grant pipeline.
  - else FIFO non-empty: grant FIFO head.
  - else no write.
- rf_we/rf_wn/rf_d carry the granted source; all zero when nothing is granted. A FIFO grant pops the head.
- Enqueue happens when mdu_valid && mdu_ready.
  - mdu_wn == 0: the handshake completes and the entry is discarded.
  - No bypass: an accepted result is stored and becomes writable the next cycle at the earliest.
- mdu_ready = fifo_cnt < DEPTH. It is derived from registered count only, with no path from wb_*. Push and pop in the same cycle on a full FIFO is impossible because ready is low.
- FIFO is in-order with wrap-around read and write pointers. Same-cycle push and pop leaves the count unchanged.
- Starvation counter (starve_cnt):
  - Clears on reset, on a pop, or when the FIFO is empty.
  - Otherwise increments each cycle the FIFO is non-empty and not popped.
  - stall_req (registered) is set next cycle when starve_cnt == STARVE_MAX-1 and there is no pop this cycle.
  - stall_req is high exactly one cycle, then clears. Its forced pop clears starve_cnt.
- pend_a = OR over valid FIFO entries of (entry_wn == qa_n) && qa_n != 0; pend_b likewise.
  - Compares registered FIFO contents only. An entry being pushed this cycle is visible next cycle.
  - WAW/RAW ordering with pipeline writes is the issuer's responsibility via pend_*.
- Reset (clrn=0 at a rising edge) applies regardless of other inputs:
  - FIFO emptied, pointers 0, fifo_cnt=0, starve_cnt=0, stall_req=0.
  - Mid-queue results are dropped.
  - While clrn=0: rf_we=0, mdu_ready=0, pend_a/pend_b=0.

## Timing
- Reset values: rf_we=0, rf_wn=0, rf_d=0, mdu_ready=0 while clrn=0, then 1; stall_req=0, pend_a/b=0, fifo_cnt=0.
- MDU accept-to-write latency is 1 cycle minimum (idle WB). Worst case with a saturated pipeline is (queue position+1)·(STARVE_MAX+1) cycles.
- Pipeline write latency is 0: the rf_* outputs follow wb_* in the same cycle. The register file samples on the falling edge.
- fifo_cnt, stall_req and pend_* are glitch-free relative to wb_*: they depend only on registered state and qa_n/qb_n.

## Test plan
- Reset: hold clrn=0 two cycles with mdu_valid=1 and wb_wreg=1 → rf_we=0, mdu_ready=0, fifo_cnt=0. Release → mdu_ready=1 next cycle.
- Idle drain: wb_wreg=0; push {wn=5, d=0x1234} → next cycle rf_we=1, rf_wn=5, rf_d=0x1234, fifo_cnt returns to 0.
- Priority and starvation (STARVE_MAX=4):
  - Push {wn=7, d=0xA}, then hold wb_wreg=1, wb_wn=3 → rf_wn=3 for 4 cycles, then stall_req=1 for one cycle with rf_wn=7, rf_d=0xA.
  - stall_req then returns to 0 and pipeline writes resume.
- Full FIFO: with wb_wreg=1 continuously, push 4 results → mdu_ready=0 and fifo_cnt=4. A fifth mdu_valid is not accepted. After one pop, mdu_ready=1.
- r0 handling:
  - wb_wreg=1, wb_wn=0 with FIFO holding wn=9 → FIFO head written (rf_wn=9).
  - MDU push with mdu_wn=0 → accepted, fifo_cnt unchanged, never written.
- Pending/wrap:
  - Queue wn=12 → pend_a=1 for qa_n=12 until the cycle after its pop; qa_n=0 → pend_a=0.
  - Stream 10 push/pop pairs → in-order data across pointer wrap.
